// File: rtl/muldiv_pkg.sv
// muldiv_pkg: opcodes, sequencer states and unit latencies shared by
// hilo_ctrl and the divider/multiplier benches.
package muldiv_pkg;
   localparam logic [1:0] OP_MULT = 2'b00;
   localparam logic [1:0] OP_DIV  = 2'b01;
   localparam logic [1:0] OP_MTHI = 2'b10;
   localparam logic [1:0] OP_MTLO = 2'b11;

   localparam int DIV_LATENCY_DEF  = 34;
   localparam int MULT_LATENCY_DEF = 34;

   typedef enum logic [1:0] {IDLE, WAIT_DIV, WAIT_MULT} state_t;
endpackage

// File: rtl/hilo_ctrl_if.sv
// hilo_ctrl_if: control-unit request/result bus plus divider and multiplier hookup.
interface hilo_ctrl_if;
   logic        op_valid;
   logic [1:0]  op_code;
   logic [31:0] rs_value;
   logic [31:0] rt_value;
   logic        div_start;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] div_hi;
   logic [31:0] div_lo;
   logic        div_zero;
   logic        mult_start;
   logic [31:0] mult_a;
   logic [31:0] mult_b;
   logic [31:0] mult_hi;
   logic [31:0] mult_lo;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div0_exc;

   modport slave (
      input  op_valid, op_code, rs_value, rt_value,
      input  div_hi, div_lo, div_zero, mult_hi, mult_lo,
      output div_start, div_a, div_b, mult_start, mult_a, mult_b,
      output hi, lo, busy, done, div0_exc
   );

   modport master (
      output op_valid, op_code, rs_value, rt_value,
      output div_hi, div_lo, div_zero, mult_hi, mult_lo,
      input  div_start, div_a, div_b, mult_start, mult_a, mult_b,
      input  hi, lo, busy, done, div0_exc
   );
endinterface

// File: rtl/op_latency_counter.sv
// op_latency_counter: loadable down-counter; tc is high once the count has drained to zero.
module op_latency_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   input  logic             enable,
   output logic             tc
);
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset) cnt <= '0;
      else if (load) cnt <= value;
      else if (enable && cnt != '0) cnt <= cnt - 1'b1;
   end

   assign tc = cnt == '0;
endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO register pair and MULT/DIV/MTHI/MTLO sequencer for the multicycle datapath.
module hilo_ctrl
   import muldiv_pkg::*;
#(
   parameter int DIV_LATENCY  = DIV_LATENCY_DEF,
   parameter int MULT_LATENCY = MULT_LATENCY_DEF,
   parameter int CNT_W        = 6
) (
   input logic        clock,
   input logic        reset,
   hilo_ctrl_if.slave bus
);
   state_t state, state_n;
   logic accept, start_div, start_mult, dz, fin, tc;
   logic [31:0] hi_n, lo_n;

   op_latency_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock  (clock),
      .reset  (reset),
      .load   (start_div || start_mult),
      .value  (start_div ? CNT_W'(DIV_LATENCY) : CNT_W'(MULT_LATENCY)),
      .enable (state != IDLE),
      .tc     (tc)
   );

   // div_zero is ignored while div_start is still high: the divider has not yet seen the new operands
   always_comb begin
      accept     = state == IDLE && bus.op_valid;
      start_div  = accept && bus.op_code == OP_DIV;
      start_mult = accept && bus.op_code == OP_MULT;
      dz         = state == WAIT_DIV && !bus.div_start && bus.div_zero;
      fin        = state != IDLE && tc && !dz;
      state_n    = start_div ? WAIT_DIV : start_mult ? WAIT_MULT : (dz || fin) ? IDLE : state;
      hi_n       = bus.hi;
      lo_n       = bus.lo;
      if (accept && bus.op_code == OP_MTHI) hi_n = bus.rs_value;
      if (accept && bus.op_code == OP_MTLO) lo_n = bus.rs_value;
      if (fin) begin
         hi_n = state == WAIT_DIV ? bus.div_hi : bus.mult_hi;
         lo_n = state == WAIT_DIV ? bus.div_lo : bus.mult_lo;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         bus.div_start  <= 1'b0;
         bus.mult_start <= 1'b0;
         bus.div_a      <= '0;
         bus.div_b      <= '0;
         bus.mult_a     <= '0;
         bus.mult_b     <= '0;
         bus.hi         <= '0;
         bus.lo         <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.div0_exc   <= 1'b0;
      end else begin
         state          <= state_n;
         bus.div_start  <= start_div;
         bus.mult_start <= start_mult;
         bus.hi         <= hi_n;
         bus.lo         <= lo_n;
         bus.busy       <= state_n != IDLE;
         bus.done       <= fin;
         bus.div0_exc   <= dz;
         if (start_div) begin
            bus.div_a <= bus.rs_value;
            bus.div_b <= bus.rt_value;
         end
         if (start_mult) begin
            bus.mult_a <= bus.rs_value;
            bus.mult_b <= bus.rt_value;
         end
      end
   end
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed vectors against behavioural divider/multiplier models
// whose results only become valid the cycle before the sequencer must capture them.
module tb_hilo_ctrl;
   import muldiv_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int n_checks = 0, n_fail = 0;
   int n_ds, n_ms, n_done, n_exc, n_both = 0;
   int dcnt, mcnt, n;

   hilo_ctrl_if bus();
   hilo_ctrl dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   // Garbage until LATENCY-1 edges after start is sampled, so an early capture is visible
   always @(posedge clock) begin
      if (reset) begin
         dcnt <= 0;
         bus.div_zero <= 1'b0;
         bus.div_hi <= '0;
         bus.div_lo <= '0;
      end else if (bus.div_start) begin
         dcnt <= DIV_LATENCY_DEF - 1;
         bus.div_hi <= 32'hBAD0BAD0;
         bus.div_lo <= 32'hBAD0BAD0;
         bus.div_zero <= bus.div_b == 0;
      end else if (dcnt != 0) begin
         dcnt <= dcnt - 1;
         if (dcnt == 1 && bus.div_b != 0) begin
            bus.div_hi <= $signed(bus.div_a) % $signed(bus.div_b);
            bus.div_lo <= $signed(bus.div_a) / $signed(bus.div_b);
         end
      end
   end

   always @(posedge clock) begin
      if (reset) begin
         mcnt <= 0;
         bus.mult_hi <= '0;
         bus.mult_lo <= '0;
      end else if (bus.mult_start) begin
         mcnt <= MULT_LATENCY_DEF - 1;
         bus.mult_hi <= 32'hBAD1BAD1;
         bus.mult_lo <= 32'hBAD1BAD1;
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 1;
         if (mcnt == 1) {bus.mult_hi, bus.mult_lo} <= 64'($signed(bus.mult_a)) * 64'($signed(bus.mult_b));
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      if (bus.div_start) n_ds++;
      if (bus.mult_start) n_ms++;
      if (bus.done) n_done++;
      if (bus.div0_exc) n_exc++;
      if ((bus.div_start && bus.mult_start) || (bus.done && bus.div0_exc)) n_both++;
   endtask

   task automatic clr();
      n_ds = 0; n_ms = 0; n_done = 0; n_exc = 0;
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.op_valid = 1'b1;
      bus.op_code  = op;
      bus.rs_value = a;
      bus.rt_value = b;
      tick();
      bus.op_valid = 1'b0;
   endtask

   task automatic wait_idle(inout int cnt);
      while (bus.busy && cnt < 100) begin
         tick();
         cnt++;
      end
   endtask

   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      clr();
      issue(OP_DIV, a, b);
      check({tag, "_start"}, 32'(bus.div_start), 1);
      check({tag, "_a"}, bus.div_a, a);
      check({tag, "_b"}, bus.div_b, b);
      n = 0;
      wait_idle(n);
      check({tag, "_lat"}, n, 35);
      check({tag, "_nstart"}, n_ds, 1);
      check({tag, "_done"}, 32'(bus.done), 1);
      check({tag, "_hi"}, bus.hi, exp_hi);
      check({tag, "_lo"}, bus.lo, exp_lo);
      tick();
      check({tag, "_done_pulse"}, n_done, 1);
      check({tag, "_exc"}, n_exc, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.op_valid = 1'b0;
      bus.op_code  = OP_MULT;
      bus.rs_value = '0;
      bus.rt_value = '0;
      reset = 1'b1;
      tick();
      tick();
      check("rst_hi", bus.hi, 0);
      check("rst_lo", bus.lo, 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_strobes", {28'd0, bus.div_start, bus.mult_start, bus.done, bus.div0_exc}, 0);
      reset = 1'b0;
      tick();

      issue(OP_MTHI, 32'hDEADBEEF, 32'h0);
      check("mthi_hi", bus.hi, 32'hDEADBEEF);
      check("mthi_busy", 32'(bus.busy), 0);
      issue(OP_MTLO, 32'h12345678, 32'h0);
      check("mtlo_lo", bus.lo, 32'h12345678);
      check("mtlo_hi", bus.hi, 32'hDEADBEEF);
      check("mtlo_busy", 32'(bus.busy), 0);

      run_div("div100_7", 32'd100, 32'd7, 32'd2, 32'd14);
      run_div("divm7_2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);

      clr();
      issue(OP_DIV, 32'd5, 32'd0);
      check("dz_busy_e0", 32'(bus.busy), 1);
      tick();
      check("dz_exc_e1", 32'(bus.div0_exc), 0);
      tick();
      check("dz_exc_e2", 32'(bus.div0_exc), 1);
      check("dz_busy_e2", 32'(bus.busy), 0);
      check("dz_done_e2", 32'(bus.done), 0);
      check("dz_hi", bus.hi, 32'hFFFFFFFF);
      check("dz_lo", bus.lo, 32'hFFFFFFFD);
      repeat (40) tick();
      check("dz_nexc", n_exc, 1);
      check("dz_ndone", n_done, 0);
      check("dz_hi_late", bus.hi, 32'hFFFFFFFF);

      clr();
      issue(OP_MULT, 32'd3, 32'd4);
      check("mul_start", 32'(bus.mult_start), 1);
      $display("note: op_valid raised while busy (protocol violation), expecting it to be ignored");
      bus.op_valid = 1'b1;
      bus.op_code  = OP_MTLO;
      bus.rs_value = 32'h55555555;
      bus.rt_value = 32'h0;
      tick();
      tick();
      bus.op_code = OP_DIV;
      tick();
      bus.op_valid = 1'b0;
      check("mul_ign_lo", bus.lo, 32'hFFFFFFFD);
      check("mul_ign_busy", 32'(bus.busy), 1);
      check("mul_ign_a", bus.mult_a, 32'd3);
      n = 3;
      wait_idle(n);
      check("mul_lat", n, 35);
      check("mul_hi", bus.hi, 32'd0);
      check("mul_lo", bus.lo, 32'd12);
      tick();
      check("mul_nstart", n_ms, 1);
      check("mul_nds", n_ds, 0);
      check("mul_ndone", n_done, 1);

      issue(OP_DIV, 32'd1000, 32'd3);
      repeat (9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_hi", bus.hi, 0);
      check("mid_lo", bus.lo, 0);
      check("mid_busy", 32'(bus.busy), 0);
      check("mid_div_a", bus.div_a, 0);
      clr();
      repeat (40) tick();
      check("mid_ndone", n_done, 0);
      check("mid_nexc", n_exc, 0);
      run_div("div1000_3", 32'd1000, 32'd3, 32'd1, 32'd333);

      check("exclusive_strobes", n_both, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
- Sequencer and HI/LO architectural register pair for the multicycle MIPS datapath; sits between the control unit and the divider/multiplier boxes.
- Accepts MULT/DIV/MTHI/MTLO requests, launches the divider or multiplier with a one-cycle start pulse, and holds operands stable for the whole operation.
- Counts the fixed unit latency, captures the unit's HI/LO outputs, and flags divide-by-zero.
- Feeds MFHI/MFLO through its `hi`/`lo` outputs; the control unit stalls on `busy`.

Parameters:
- DIV_LATENCY, 34: rising edges from the divider sampling `div_start` to a valid divider HI/LO.
- MULT_LATENCY, 34: rising edges from the multiplier sampling `mult_start` to a valid multiplier HI/LO.
- CNT_W, 6: latency counter width; must satisfy 2^CNT_W > max(DIV_LATENCY, MULT_LATENCY).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  request strobe from the control unit
- op_code  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
- rs_value  in  32  operand A; MTHI/MTLO source
- rt_value  in  32  operand B
- div_start  out  1  one-cycle start to the divider
- div_a  out  32  dividend; registered and held
- div_b  out  32  divisor; registered and held
- div_hi  in  32  divider remainder
- div_lo  in  32  divider quotient
- div_zero  in  1  divider divide-by-zero flag
- mult_start  out  1  one-cycle start to the multiplier
- mult_a  out  32  multiplicand; registered and held
- mult_b  out  32  multiplier; registered and held
- mult_hi  in  32  product high word
- mult_lo  in  32  product low word
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- busy  out  1  operation in flight; the control unit must stall
- done  out  1  one-cycle pulse on successful capture
- div0_exc  out  1  one-cycle pulse on divide-by-zero

Behaviour:
- Clocking: reset is synchronous, active-high; clock is `clock`. All outputs are registered.
- Reset values: hi=lo=0, div_a=div_b=mult_a=mult_b=0, all strobes=0, busy=0, state=IDLE, counter=0.
- Reset mid-operation behaves identically: operation dropped, no done, no exception.
- FSM states: IDLE, WAIT_DIV, WAIT_MULT.
- IDLE, op_valid=1 at edge E0:
  - DIV: latch div_a=rs_value and div_b=rt_value; div_start=1 for the one cycle after E0; counter=DIV_LATENCY; busy=1; go to WAIT_DIV.
  - MULT: same using the mult_* ports and MULT_LATENCY; go to WAIT_MULT.
  - MTHI: hi=rs_value at E0; stay IDLE; busy stays 0.
  - MTLO: lo=rs_value at E0; stay IDLE; busy stays 0.
- WAIT_*: the unit samples start at E1. The counter decrements on each edge from E1 onward.
- Capture: on the edge where the counter is 1 (E1+LATENCY-1), then at E1+LATENCY:
  - hi/lo are loaded from the unit outputs;
  - done=1 for one cycle;
  - busy=0;
  - state returns to IDLE.
- Total op latency with defaults: 35 cycles from acceptance to visible result.
- Operand hold: div_a/div_b and mult_a/mult_b stay constant from E0 until the next accepted op. The divider reads its inputs again at completion for the sign fix-up, so they must not change.
- Divide-by-zero: in WAIT_DIV, div_zero is sampled from E2 onward. If it is high:
  - div0_exc=1 for one cycle;
  - hi/lo are left unchanged;
  - no done pulse;
  - busy=0 and state returns to IDLE on that edge.
- op_valid while busy=1: ignored, with no state change. The bench flags it as a protocol violation.
- div_start and mult_start are never high simultaneously, and never high for more than one cycle.
- done and div0_exc are mutually exclusive.
- Results are captured verbatim with no width changes. Signedness is handled inside the units.

Decomposition:
- Package muldiv_pkg holds:
  - op_code constants OP_MULT, OP_DIV, OP_MTHI, OP_MTLO;
  - the FSM state enum;
  - default DIV_LATENCY/MULT_LATENCY values, shared with the divider and multiplier testbenches.
- One sub-module, op_latency_counter:
  - inputs: load, load value, enable;
  - output: a terminal-count flag;
  - instantiated once and shared by both WAIT states.

Test Plan:
- Reset: reset held 2 cycles -> hi=lo=0, busy=0, no strobes.
- MTHI then MTLO: MTHI rs=0xDEADBEEF, then MTLO rs=0x12345678 -> hi=0xDEADBEEF, lo=0x12345678 one edge after each op; busy never asserted.
- DIV with divider model: rs=100, rt=7 -> div_start exactly 1 cycle; busy for 35 cycles; then lo=14, hi=2, done pulse. Then rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide-by-zero: DIV rs=5, rt=0 -> div0_exc pulse at E2, no done, prior hi/lo retained, busy=0 after E2.
- Op while busy: MULT rs=3, rt=4 accepted, then op_valid pulses with MTLO mid-flight -> ignored; after MULT_LATENCY, hi=0, lo=12.
- Reset mid-op: reset at cycle 10 of a DIV -> hi=lo=0, busy=0, no done or div0_exc afterwards; the next DIV completes normally.
